// File: rtl/handshake_rx_if.sv
// Downstream valid/ready bundle of the handshake receiver.
// master drives data/valid, slave returns ready.
interface handshake_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/handshake_rx.sv
// Receiver side of a 4-phase req/ack word handshake into clk_B.
// Captures the source word once per req pulse and hands it on via valid/ready.
module handshake_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 256,
    parameter int CNT_W       = 16
) (
    input  logic              clk_B,
    input  logic              rst_B,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    handshake_rx_if.master    out_if,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  xfer_cnt
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic [DATA_W-1:0]      data_q;
    logic                   valid_q;
    logic                   ack_q;
    logic                   err_q;
    logic [TW-1:0]          tmo_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   tmo_hit;

    assign req_s = sync_q[SYNC_STAGES-1];

    // req_in is asynchronous; only the last flop of the chain is used
    always_ff @(posedge clk_B) begin
        if (rst_B) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    // Counter is about to reach TIMEOUT while the source still holds req.
    // Firing only on that one edge keeps a cleared error from re-setting.
    assign tmo_hit = (TIMEOUT != 0) && (state_q == WAIT_REL) &&
                     req_s && (tmo_q == TLAST);

    // Handshake FSM with registered outputs, counters and sticky error
    always_ff @(posedge clk_B) begin
        if (rst_B) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_s) begin
                        data_q  <= data_in;
                        valid_q <= 1'b1;
                        state_q <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // req dropping early is ignored; the word still goes out
                    if (valid_q && out_if.out_ready) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        tmo_q   <= '0;
                        state_q <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!req_s) begin
                        ack_q   <= 1'b0;
                        tmo_q   <= '0;
                        state_q <= IDLE;
                    end else if (tmo_q != TMAX) begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ack_q   <= 1'b0;
                    tmo_q   <= '0;
                end
            endcase

            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign ack_out          = ack_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_valid = valid_q;
    assign busy             = (state_q != IDLE);
    assign timeout_err      = err_q;
    assign xfer_cnt         = cnt_q;
endmodule

// File: tb/tb_handshake_rx.sv
// Directed bench for handshake_rx: one instance with the default timeout,
// one with a short timeout and narrow counter for error and stream cases.
module tb_handshake_rx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: TIMEOUT=256, CNT_W=16
    logic       rstA, reqA, ackA, busyA, errA, clrA;
    logic [7:0] dataA;
    logic [15:0] cntA;
    handshake_rx_if #(.DATA_W(8)) ifA ();

    // instance B: TIMEOUT=8, CNT_W=4
    logic       rstB, reqB, ackB, busyB, errB, clrB;
    logic [7:0] dataB;
    logic [3:0] cntB;
    handshake_rx_if #(.DATA_W(8)) ifB ();

    handshake_rx #(
        .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(256), .CNT_W(16)
    ) dutA (
        .clk_B(clk), .rst_B(rstA), .req_in(reqA), .data_in(dataA),
        .ack_out(ackA), .out_if(ifA), .busy(busyA),
        .timeout_err(errA), .err_clr(clrA), .xfer_cnt(cntA)
    );

    handshake_rx #(
        .DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(8), .CNT_W(4)
    ) dutB (
        .clk_B(clk), .rst_B(rstB), .req_in(reqB), .data_in(dataB),
        .ack_out(ackB), .out_if(ifB), .busy(busyB),
        .timeout_err(errB), .err_clr(clrB), .xfer_cnt(cntB)
    );

    int n_asrt = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    localparam int NSTRM = 40;
    bit src_done;
    int got_idx;
    int vcount;
    int n;

    function automatic logic [7:0] strm_word(input int k);
        return 8'(k * 37 + 5);
    endfunction

    initial begin
        rstA = 1'b1; reqA = 1'b0; dataA = '0; clrA = 1'b0;
        rstB = 1'b1; reqB = 1'b0; dataB = '0; clrB = 1'b0;
        ifA.out_ready = 1'b0;
        ifB.out_ready = 1'b0;
        src_done = 1'b0;
        got_idx = 0;
        tick(3);

        // reset state
        check("rst_valid", ifA.out_valid, 0);
        check("rst_data", ifA.out_data, 0);
        check("rst_ack", ackA, 0);
        check("rst_busy", busyA, 0);
        check("rst_err", errA, 0);
        check("rst_cnt", cntA, 0);
        rstA = 1'b0;
        rstB = 1'b0;
        tick(1);

        // single transfer
        dataA = 8'hA5; reqA = 1'b1; ifA.out_ready = 1'b1;
        tick(2);
        check("t1_valid_e1", ifA.out_valid, 0);
        tick(1);
        check("t1_valid_e2", ifA.out_valid, 1);
        check("t1_data_e2", ifA.out_data, 8'hA5);
        check("t1_busy_e2", busyA, 1);
        check("t1_ack_e2", ackA, 0);
        tick(1);
        check("t1_ack_e3", ackA, 1);
        check("t1_valid_e3", ifA.out_valid, 0);
        check("t1_cnt", cntA, 1);
        reqA = 1'b0;
        tick(2);
        check("t1_ack_r1", ackA, 1);
        tick(1);
        check("t1_ack_r2", ackA, 0);
        check("t1_busy_r2", busyA, 0);
        check("t1_cnt_end", cntA, 1);

        // backpressure
        ifA.out_ready = 1'b0;
        dataA = 8'hA5; reqA = 1'b1;
        tick(3);
        check("bp_valid", ifA.out_valid, 1);
        dataA = 8'h3C;
        tick(10);
        check("bp_data_hold", ifA.out_data, 8'hA5);
        check("bp_valid_hold", ifA.out_valid, 1);
        check("bp_ack_low", ackA, 0);
        ifA.out_ready = 1'b1;
        tick(1);
        check("bp_ack", ackA, 1);
        check("bp_valid_drop", ifA.out_valid, 0);
        check("bp_cnt", cntA, 2);

        // held request: no second capture, no timeout
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (ifA.out_valid) vcount++;
        end
        check("held_no_valid", vcount, 0);
        check("held_err", errA, 0);
        check("held_ack", ackA, 1);
        check("held_busy", busyA, 1);
        reqA = 1'b0;
        tick(3);
        check("held_rel_ack", ackA, 0);
        check("held_rel_busy", busyA, 0);
        check("held_cnt", cntA, 2);

        // reset in WAIT_RDY, then req still high after reset
        ifA.out_ready = 1'b0;
        dataA = 8'h77; reqA = 1'b1;
        tick(3);
        check("mr_valid_pre", ifA.out_valid, 1);
        rstA = 1'b1;
        tick(1);
        check("mr_valid", ifA.out_valid, 0);
        check("mr_data", ifA.out_data, 0);
        check("mr_ack", ackA, 0);
        check("mr_busy", busyA, 0);
        check("mr_cnt", cntA, 0);
        rstA = 1'b0;
        tick(2);
        check("mr_valid_e1", ifA.out_valid, 0);
        tick(1);
        check("mr_valid_e2", ifA.out_valid, 1);
        check("mr_data_e2", ifA.out_data, 8'h77);
        ifA.out_ready = 1'b1;
        tick(1);
        check("mr_ack", ackA, 1);
        reqA = 1'b0;
        tick(3);
        check("mr_rel", ackA, 0);

        // timeout on instance B
        dataB = 8'h11; reqB = 1'b1; ifB.out_ready = 1'b1;
        tick(4);
        check("to_ack", ackB, 1);
        tick(7);
        check("to_err_early", errB, 0);
        tick(1);
        check("to_err_set", errB, 1);
        clrB = 1'b1;
        tick(1);
        clrB = 1'b0;
        check("to_err_clr", errB, 0);
        check("to_busy", busyB, 1);
        check("to_ack_hold", ackB, 1);
        tick(5);
        check("to_err_stays_clr", errB, 0);
        reqB = 1'b0;
        tick(3);
        check("to_idle_busy", busyB, 0);
        check("to_idle_ack", ackB, 0);
        check("to_cnt", cntB, 1);

        // stream with random backpressure; 4-bit counter wraps
        fork
            begin
                for (int k = 0; k < NSTRM; k++) begin
                    dataB = strm_word(k);
                    reqB = 1'b1;
                    n = 0;
                    while (ackB !== 1'b1 && n < 200) begin
                        tick(1);
                        n++;
                    end
                    check("strm_ack_hi", ackB, 1);
                    reqB = 1'b0;
                    n = 0;
                    while (ackB !== 1'b0 && n < 200) begin
                        tick(1);
                        n++;
                    end
                    check("strm_ack_lo", ackB, 0);
                end
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    @(negedge clk);
                    ifB.out_ready = 1'($urandom_range(0, 1));
                    if (ifB.out_ready && ifB.out_valid) begin
                        check("strm_data", ifB.out_data, strm_word(got_idx));
                        got_idx++;
                    end
                end
            end
        join
        check("strm_count", got_idx, NSTRM);
        tick(2);
        check("strm_cnt_wrap", cntB, (NSTRM + 1) % 16);
        check("strm_err", errB, 0);
        check("strm_busy", busyB, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/handshake_rx.md
# handshake_rx

Receiving end of the 4-phase req/ack data handshake that carries a multi-bit word from a faster source domain into the clk_B domain. The block synchronizes the asynchronous `req_in`, captures the source-held `data_in`, and presents it downstream with valid/ready. It returns `ack_out` only after the consumer accepts the word, then waits for `req_in` to drop before it accepts the next word. It is the receiver counterpart to the existing transmitter-side handshake logic.

## Interface
- `DATA_W`, 8: width of transferred word.
- `SYNC_STAGES`, 2: flops in the `req_in` synchronizer, minimum 2.
- `TIMEOUT`, 256: clk_B cycles allowed in WAIT_REL before `timeout_err` sets; 0 disables.
- `CNT_W`, 16: width of `xfer_cnt`.

- `clk_B`  in  1  receive-domain clock; the only clock.
- `rst_B`  in  1  synchronous reset, active-high.
- `req_in`  in  1  request from source domain, asynchronous to clk_B.
- `data_in`  in  DATA_W  source word; stable from before `req_in` rises until `ack_out` is seen high.
- `ack_out`  out  1  acknowledge to source domain, registered.
- `out_data`  out  DATA_W  captured word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  downstream accepts when high with `out_valid`.
- `busy`  out  1  high whenever state is not IDLE.
- `timeout_err`  out  1  sticky: `req_in` failed to drop within TIMEOUT cycles.
- `err_clr`  in  1  single-cycle clear of `timeout_err`.
- `xfer_cnt`  out  CNT_W  count of accepted words, wraps modulo 2^CNT_W.

## Operation
- `req_in` passes through a SYNC_STAGES flop chain; only the last stage (`req_s`) drives logic. `data_in` is never synchronized; it is sampled only on the capture edge.
- States: IDLE, WAIT_RDY, WAIT_REL.
- IDLE:
  - `req_s`=1 → `out_data`<=`data_in`, `out_valid`<=1, go to WAIT_RDY.
  - Otherwise hold.
- WAIT_RDY:
  - `out_valid` and `out_data` are held.
  - `out_valid`&`out_ready` → `out_valid`<=0, `ack_out`<=1, `xfer_cnt`+=1, go to WAIT_REL.
  - `req_s` dropping here is a protocol violation; it is ignored and the word is still delivered.
- WAIT_REL:
  - `ack_out` held at 1; the timeout counter increments each cycle.
  - `req_s`=0 → `ack_out`<=0, counter cleared, go to IDLE.
  - Counter reaches TIMEOUT (TIMEOUT≠0) → `timeout_err`<=1. The block stays in WAIT_REL and keeps waiting. The counter saturates.
- `timeout_err` clears on `err_clr` or reset. If `err_clr` and a new set occur in the same cycle, set wins.
- A new word is never captured until `req_s` has been seen low after the previous ack. This gives exactly one capture per req pulse.
- `busy` = (state != IDLE), combinational from the state register.

## Timing
- Reset values: `ack_out`=0, `out_valid`=0, `out_data`=0, `busy`=0, `timeout_err`=0, `xfer_cnt`=0. Sync chain cleared, state IDLE, timeout counter 0.
- Reset mid-operation aborts the transfer with no ack. If `req_in` is still high after reset, it is treated as a new request, so the source must be reset together with this block.
- Capture latency: edge E0 is the first clk_B edge that samples `req_in`=1.
  - `req_s`=1 after edge E0+SYNC_STAGES−1.
  - `out_valid`=1 and `out_data` updated after edge E0+SYNC_STAGES.
- Accept: a handshake at edge Ea gives `out_valid`=0, `ack_out`=1 and the `xfer_cnt` increment all visible after Ea. `out_ready` high in the first `out_valid` cycle is accepted; minimum valid width is 1 cycle.
- Release: `req_in` falls, first sampled low at edge R0. Then `ack_out`=0 and `busy`=0 after R0+SYNC_STAGES.
- Earliest next capture: the first edge after returning to IDLE at which `req_s`=1.
- `timeout_err` rises after the TIMEOUT-th edge spent in WAIT_REL.
- `xfer_cnt` wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan
- Single transfer, SYNC_STAGES=2, `out_ready`=1, `data_in`=8'hA5, `req_in` raised before edge 0 → `out_valid`=1 and `out_data`=8'hA5 after edge 2, `ack_out`=1 after edge 3. Drop `req_in` → `ack_out`=0 two edges later; `xfer_cnt`=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` rises, `data_in` changed after capture → `out_data` stays 8'hA5, `ack_out` stays 0 until `out_ready`=1, then `ack_out`=1 the next edge.
- Held request: keep `req_in`=1 for 50 cycles after `ack_out` rises → no second `out_valid`. `timeout_err` stays 0 with TIMEOUT=256.
- Timeout: TIMEOUT=8, `req_in` held high → `timeout_err`=1 after 8 cycles in WAIT_REL. `err_clr` pulse → 0 while still waiting. Dropping `req_in` returns to IDLE.
- Reset mid-transfer: assert `rst_B` in WAIT_RDY → all outputs 0 next edge. Deassert with `req_in`=1 → a new capture occurs SYNC_STAGES+1 edges later.
- Back-to-back stream: 70000 transfers with CNT_W=16 and random `out_ready` → data sequence matches the source in order with no duplicates or drops. `xfer_cnt` = 70000 mod 65536 = 4464.
